// File: rtl/data_memory_unit_if.sv
// CPU-side data bus: address, write data, write strobe and combinational read data.
interface data_memory_unit_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] BusA;
   logic [DATA_WIDTH-1:0] BusB;
   logic                  MW;
   logic [DATA_WIDTH-1:0] DataIn;

   modport master (output BusA, output BusB, output MW, input DataIn);
   modport slave  (input BusA, input BusB, input MW, output DataIn);
endinterface

// File: rtl/data_memory_unit.sv
// Data memory responder: RAM below MMIO_BASE, memory-mapped I/O in the top addresses
// (write counter, cycle counter, output port, synchronized switches).
module data_memory_unit #(
   parameter int unsigned           ADDR_WIDTH = 8,
   parameter int unsigned           DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 8'hF0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   data_memory_unit_if.slave     bus,
   input  logic [DATA_WIDTH-1:0] Switches,
   output logic [DATA_WIDTH-1:0] PortOut,
   output logic                  PortStrobe
);

   localparam int unsigned RAM_DEPTH = int'(MMIO_BASE);

   // MMIO registers live at the very top of the address space
   localparam logic [ADDR_WIDTH-1:0] ADDR_SW   = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_PORT = ADDR_SW - ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_CYC  = ADDR_SW - ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] ADDR_WCNT = ADDR_SW - ADDR_WIDTH'(3);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
   logic [DATA_WIDTH-1:0] writeCnt;
   logic [DATA_WIDTH-1:0] cycleCnt;
   logic [DATA_WIDTH-1:0] swMeta;
   logic [DATA_WIDTH-1:0] swSync;

   logic isRam;
   logic isPort;
   logic ramWrite;
   logic portWrite;

   assign isRam     = (bus.BusA < MMIO_BASE);
   assign isPort    = (bus.BusA == ADDR_PORT);
   assign ramWrite  = bus.MW && isRam;
   assign portWrite = bus.MW && isPort;

   // RAM storage: no reset; writes are blocked while Reset is held
   always_ff @(posedge Clock) begin
      if (ramWrite && !Reset) begin
         mem[bus.BusA] <= bus.BusB;
      end
   end

   // Output port register and its one-cycle write strobe
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         PortOut    <= '0;
         PortStrobe <= 1'b0;
      end else begin
         PortStrobe <= portWrite;
         if (portWrite) begin
            PortOut <= bus.BusB;
         end
      end
   end

   // Free-running cycle counter (wraps) and saturating accepted-write counter
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         cycleCnt <= '0;
         writeCnt <= '0;
      end else begin
         cycleCnt <= cycleCnt + DATA_WIDTH'(1);
         if ((ramWrite || portWrite) && (writeCnt != {DATA_WIDTH{1'b1}})) begin
            writeCnt <= writeCnt + DATA_WIDTH'(1);
         end
      end
   end

   // Two-flop synchronizer for the asynchronous board switches
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         swMeta <= '0;
         swSync <= '0;
      end else begin
         swMeta <= Switches;
         swSync <= swMeta;
      end
   end

   // Zero-latency read decode; unmapped MMIO reads as zero
   always_comb begin
      bus.DataIn = '0;
      if (isRam) begin
         bus.DataIn = mem[bus.BusA];
      end else begin
         unique case (bus.BusA)
            ADDR_WCNT: bus.DataIn = writeCnt;
            ADDR_CYC:  bus.DataIn = cycleCnt;
            ADDR_PORT: bus.DataIn = PortOut;
            ADDR_SW:   bus.DataIn = swSync;
            default:   bus.DataIn = '0;
         endcase
      end
   end

endmodule
